ws2812_pixel_encoder: RTL and testbench

Parametrised successor to the single-bit WS2812 unipolar RZ encoder.
- Accepts whole pixels (24-bit GRB or 32-bit GRBW) over a valid/ready handshake.
- Serialises each pixel MSB-first into RZ-coded pulses, gap-free between back-to-back pixels.
- Generates the strip latch/reset low period on command, or automatically at end of stream.
- Sits between the frame-buffer reader and the LED-strip output pin.

---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_phase_counter.sv | 31 +++
 rtl/ws2812_pixel_encoder.sv | 156 +++++++++++++++
 tb/tb_ws2812_pixel_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared command/state encodings and 10 MHz default timing for the WS2812 pixel encoder.
package ws2812_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_TX    = 2'b01,
        CMD_LATCH = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_e;

    localparam int DEF_BITS_PER_PIXEL = 24;
    localparam int DEF_T0H_CYC        = 4;
    localparam int DEF_T1H_CYC        = 8;
    localparam int DEF_TBIT_CYC       = 13;
    localparam int DEF_RESET_CYC      = 500;

endpackage

// File: rtl/ws2812_phase_counter.sv
// Loadable down-counter that idles at zero; tc flags the final cycle of a loaded phase.
module ws2812_phase_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == '0);

endmodule

// File: rtl/ws2812_pixel_encoder.sv
// Serialises GRB/GRBW pixels into WS2812 RZ pulses with gapless back-to-back pixels and latch generation.
module ws2812_pixel_encoder
    import ws2812_pkg::*;
#(
    parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
    parameter int T0H_CYC        = DEF_T0H_CYC,
    parameter int T1H_CYC        = DEF_T1H_CYC,
    parameter int TBIT_CYC       = DEF_TBIT_CYC,
    parameter int RESET_CYC      = DEF_RESET_CYC,
    parameter bit AUTO_LATCH     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                cmd,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic                      busy,
    output logic                      data_out
);

    localparam int PW = $clog2(((TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC) + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL);

    // Counter reload values are phase length minus one; tc marks the last cycle.
    localparam logic [PW-1:0] T0H_LD = PW'(T0H_CYC - 1);
    localparam logic [PW-1:0] T1H_LD = PW'(T1H_CYC - 1);
    localparam logic [PW-1:0] T0L_LD = PW'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [PW-1:0] T1L_LD = PW'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [PW-1:0] RST_LD = PW'(RESET_CYC - 1);

    if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && RESET_CYC >= 1 &&
          (BITS_PER_PIXEL == 24 || BITS_PER_PIXEL == 32))) begin : g_bad_params
        $error("ws2812_pixel_encoder: illegal timing or pixel width parameters");
    end

    state_e                    state_d, state_q;
    logic [BITS_PER_PIXEL-1:0] shift_d, shift_q;
    logic [BW-1:0]             bit_d, bit_q;
    logic                      data_d, data_q;
    logic                      busy_d, busy_q;
    logic                      ready_d, ready_q;
    logic                      ld;
    logic [PW-1:0]             ld_val, cnt;
    logic                      tc, take, tx;

    ws2812_phase_counter #(.W(PW)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .count    (cnt),
        .tc       (tc)
    );

    assign tx   = (cmd_e'(cmd) == CMD_TX);
    assign take = ready_q && pixel_valid;

    // ready is registered, so it is raised one cycle ahead of the cycle that may accept.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        data_d  = data_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        ld      = 1'b0;
        ld_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_e'(cmd) == CMD_LATCH) begin
                    state_d = ST_LATCH;
                    busy_d  = 1'b1;
                    ld      = 1'b1;
                    ld_val  = RST_LD;
                end else if (take) begin
                    state_d = ST_HIGH;
                    shift_d = pixel_data;
                    bit_d   = BW'(BITS_PER_PIXEL - 1);
                    data_d  = 1'b1;
                    busy_d  = 1'b1;
                    ld      = 1'b1;
                    ld_val  = pixel_data[BITS_PER_PIXEL-1] ? T1H_LD : T0H_LD;
                end else begin
                    ready_d = tx;
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    state_d = ST_LOW;
                    data_d  = 1'b0;
                    ld      = 1'b1;
                    ld_val  = shift_q[BITS_PER_PIXEL-1] ? T1L_LD : T0L_LD;
                    ready_d = (bit_q == '0) && (ld_val == '0) && tx;
                end
            end
            ST_LOW: begin
                if (!tc) begin
                    ready_d = (bit_q == '0) && (cnt == PW'(1)) && tx;
                end else if (bit_q != '0) begin
                    state_d = ST_HIGH;
                    shift_d = shift_q << 1;
                    bit_d   = bit_q - BW'(1);
                    data_d  = 1'b1;
                    ld      = 1'b1;
                    ld_val  = shift_q[BITS_PER_PIXEL-2] ? T1H_LD : T0H_LD;
                end else if (take) begin
                    state_d = ST_HIGH;
                    shift_d = pixel_data;
                    bit_d   = BW'(BITS_PER_PIXEL - 1);
                    data_d  = 1'b1;
                    ld      = 1'b1;
                    ld_val  = pixel_data[BITS_PER_PIXEL-1] ? T1H_LD : T0H_LD;
                end else if (AUTO_LATCH) begin
                    state_d = ST_LATCH;
                    ld      = 1'b1;
                    ld_val  = RST_LD;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = tx;
                end
            end
            ST_LATCH: begin
                if (tc) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign pixel_ready = ready_q;
    assign busy        = busy_q;
    assign data_out    = data_q;

endmodule

// File: tb/tb_ws2812_pixel_encoder.sv
// Directed bench: default, auto-latch and 32-bit encoder instances driven from shared stimulus.
module tb_ws2812_pixel_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cmd = 2'b00;
    logic        pixel_valid = 1'b0;
    logic [23:0] pix24 = '0;
    logic [31:0] pix32 = '0;
    logic [2:0]  rdy, bsy, dout;
    int          sel = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ws2812_pixel_encoder u_def (
        .clk(clk), .rst(rst), .cmd(cmd), .pixel_data(pix24), .pixel_valid(pixel_valid),
        .pixel_ready(rdy[0]), .busy(bsy[0]), .data_out(dout[0]));

    ws2812_pixel_encoder #(.AUTO_LATCH(1'b1)) u_auto (
        .clk(clk), .rst(rst), .cmd(cmd), .pixel_data(pix24), .pixel_valid(pixel_valid),
        .pixel_ready(rdy[1]), .busy(bsy[1]), .data_out(dout[1]));

    ws2812_pixel_encoder #(.BITS_PER_PIXEL(32)) u_w32 (
        .clk(clk), .rst(rst), .cmd(cmd), .pixel_data(pix32), .pixel_valid(pixel_valid),
        .pixel_ready(rdy[2]), .busy(bsy[2]), .data_out(dout[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd = 2'b00; pixel_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Samples one pixel's worth of cycles starting in the first HIGH cycle of its MSB.
    task automatic run_pixel(input logic [31:0] px, input int bpp, output int errs, output logic last_rdy);
        errs = 0;
        last_rdy = 1'b0;
        for (int j = 0; j < bpp * 13; j++) begin
            logic b, e;
            b = px[bpp - 1 - j / 13];
            e = ((j % 13) < (b ? 8 : 4));
            if (dout[sel] !== e || bsy[sel] !== 1'b1) errs++;
            if (j == bpp * 13 - 1) last_rdy = rdy[sel];
            else if (rdy[sel] !== 1'b0) errs++;
            tick();
        end
    endtask

    initial begin
        int errs;
        int cnt;
        logic lr;

        // Reset state
        sel = 0;
        do_reset();
        rst = 1'b1;
        tick();
        check("rst_data_out", {31'd0, dout[0]}, 32'd0);
        check("rst_busy", {31'd0, bsy[0]}, 32'd0);
        check("rst_ready", {31'd0, rdy[0]}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_ready_cmd_idle", {31'd0, rdy[0]}, 32'd0);

        // Single pixel A50000
        cmd = 2'b01;
        tick();
        check("idle_ready_cmd_tx", {31'd0, rdy[0]}, 32'd1);
        pix24 = 24'hA50000; pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        check("single_first_high", {31'd0, dout[0]}, 32'd1);
        run_pixel(32'h00A50000, 24, errs, lr);
        check("single_waveform_errs", errs, 0);
        check("single_after_data_out", {31'd0, dout[0]}, 32'd0);
        check("single_after_busy", {31'd0, bsy[0]}, 32'd0);
        check("single_after_ready", {31'd0, rdy[0]}, 32'd1);

        // Back-to-back FFFFFF then 000000
        do_reset();
        cmd = 2'b01;
        tick();
        pix24 = 24'hFFFFFF; pixel_valid = 1'b1;
        tick();
        pix24 = 24'h000000;
        run_pixel(32'h00FFFFFF, 24, errs, lr);
        pixel_valid = 1'b0;
        check("b2b_pix1_errs", errs, 0);
        check("b2b_final_ready", {31'd0, lr}, 32'd1);
        run_pixel(32'h00000000, 24, errs, lr);
        check("b2b_pix2_errs", errs, 0);
        check("b2b_end_busy", {31'd0, bsy[0]}, 32'd0);

        // Latch command wins over a valid pixel
        do_reset();
        tick();
        cmd = 2'b10; pix24 = 24'h123456; pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0; cmd = 2'b01;
        cnt = 0; errs = 0;
        for (int k = 0; k < 600 && bsy[0] === 1'b1; k++) begin
            if (dout[0] !== 1'b0 || rdy[0] !== 1'b0) errs++;
            cnt++;
            tick();
        end
        check("latch_busy_cycles", cnt, 500);
        check("latch_outputs_low_errs", errs, 0);
        check("latch_exit_data_out", {31'd0, dout[0]}, 32'd0);
        tick();
        check("latch_then_ready", {31'd0, rdy[0]}, 32'd1);

        // Auto latch after a lone pixel
        sel = 1;
        do_reset();
        cmd = 2'b01;
        tick();
        pix24 = 24'h00FF00; pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        cnt = 0; errs = 0;
        for (int k = 0; k < 1000 && bsy[1] === 1'b1; k++) begin
            if (cnt >= 312 && dout[1] !== 1'b0) errs++;
            cnt++;
            tick();
        end
        check("auto_busy_cycles", cnt, 812);
        check("auto_latch_low_errs", errs, 0);

        // Reset mid-pixel in HIGH of bit 10
        sel = 0;
        do_reset();
        cmd = 2'b01;
        tick();
        pix24 = 24'hA5A5A5; pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        for (int k = 0; k < 170; k++) tick();
        check("pre_reset_bit10_high", {31'd0, dout[0]}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_data_out", {31'd0, dout[0]}, 32'd0);
        check("midrst_busy", {31'd0, bsy[0]}, 32'd0);
        check("midrst_ready", {31'd0, rdy[0]}, 32'd0);
        tick();
        check("midrst_hold_busy", {31'd0, bsy[0]}, 32'd0);
        check("midrst_hold_ready", {31'd0, rdy[0]}, 32'd0);
        rst = 1'b0;
        tick();
        check("postrst_ready", {31'd0, rdy[0]}, 32'd1);
        pix24 = 24'h800001; pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        run_pixel(32'h00800001, 24, errs, lr);
        check("postrst_pixel_errs", errs, 0);
        check("postrst_end_busy", {31'd0, bsy[0]}, 32'd0);

        // 32-bit pixel
        sel = 2;
        do_reset();
        cmd = 2'b01;
        tick();
        pix32 = 32'h00000001; pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        run_pixel(32'h00000001, 32, errs, lr);
        check("w32_pixel_errs", errs, 0);
        check("w32_end_busy", {31'd0, bsy[2]}, 32'd0);
        check("w32_end_data_out", {31'd0, dout[2]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
